// File: rtl/multicycle_control_fsm.sv
// Control sequencer for a multicycle RV32I datapath: one ALU, register unit and data
// memory are time-shared across FETCH/DECODE/EXEC/WB-style states chosen from the IR.
module multicycle_control_fsm #(
  parameter int unsigned RESET_STATE_HOLD = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] opCode,
  input  logic [2:0] F3,
  input  logic [6:0] F7,
  input  logic       BrTaken,
  input  logic       MemReady,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RUWr,
  output logic       DMRd,
  output logic       DMWr,
  output logic [1:0] ALUASrc,
  output logic [1:0] ALUBSrc,
  output logic [3:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic [2:0] DMCtrl,
  output logic [1:0] RUDataWrSrc,
  output logic [3:0] State,
  output logic       InstRetired,
  output logic       IllegalInst
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EXEC    = 4'd3;
  localparam logic [3:0] S_ALUWB   = 4'd4;
  localparam logic [3:0] S_MEMADDR = 4'd5;
  localparam logic [3:0] S_MEMRD   = 4'd6;
  localparam logic [3:0] S_MEMWB   = 4'd7;
  localparam logic [3:0] S_MEMWR   = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_JUMP    = 4'd10;
  localparam logic [3:0] S_TRAP    = 4'd11;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1001;

  localparam logic [1:0] ASRC_RS1   = 2'b00;
  localparam logic [1:0] ASRC_PC    = 2'b01;
  localparam logic [1:0] ASRC_OLDPC = 2'b10;
  localparam logic [1:0] BSRC_RS2   = 2'b00;
  localparam logic [1:0] BSRC_IMM   = 2'b01;
  localparam logic [1:0] BSRC_FOUR  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] WSRC_PC  = 2'b00;
  localparam logic [1:0] WSRC_MEM = 2'b01;
  localparam logic [1:0] WSRC_ALU = 2'b10;

  localparam logic [3:0] HOLD_LAST = 4'(RESET_STATE_HOLD - 1);

  logic [3:0] state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       unused_f7;

  assign unused_f7 = ^{F7[6], F7[4:0]};

  function automatic logic [3:0] dispatch(input logic [6:0] op);
    logic [3:0] nxt;
    case (op)
      OP_R, OP_I, OP_LUI, OP_AUIPC: nxt = S_EXEC;
      OP_LOAD, OP_STORE:            nxt = S_MEMADDR;
      OP_BR:                        nxt = S_BRANCH;
      OP_JAL, OP_JALR:              nxt = S_JUMP;
      default:                      nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

  // F7[5] only selects SUB/SRA; for I-type it matters solely on the shift-right encoding.
  function automatic logic [3:0] exec_alu_op(input logic [6:0] op, input logic [2:0] f3,
                                             input logic f7b5);
    logic [3:0] res;
    case (op)
      OP_R:    res = {f7b5, f3};
      OP_I:    res = {(f3 == 3'b101) ? f7b5 : 1'b0, f3};
      OP_LUI:  res = ALU_PASSB;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

  // State and IDLE-hold registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_FETCH;
          hold_d  = 4'd0;
        end else begin
          hold_d  = hold_q + 4'd1;
        end
      end
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = dispatch(opCode);
      S_EXEC:    state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_MEMADDR: state_d = (opCode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = MemReady ? S_FETCH : S_MEMWR;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_TRAP;
    endcase
  end

  // Output decode from current state (plus IR fields, BrTaken and MemReady)
  always_comb begin
    PCWr        = 1'b0;
    IRWr        = 1'b0;
    RUWr        = 1'b0;
    DMRd        = 1'b0;
    DMWr        = 1'b0;
    ALUASrc     = ASRC_RS1;
    ALUBSrc     = BSRC_RS2;
    ALUOp       = ALU_ADD;
    ImmSrc      = IMM_I;
    DMCtrl      = 3'b000;
    RUDataWrSrc = WSRC_PC;
    InstRetired = 1'b0;
    IllegalInst = 1'b0;
    State       = state_q;
    case (state_q)
      S_FETCH: begin
        IRWr    = 1'b1;
        PCWr    = 1'b1;
        ALUASrc = ASRC_PC;
        ALUBSrc = BSRC_FOUR;
      end
      S_EXEC, S_ALUWB: begin
        ALUOp = exec_alu_op(opCode, F3, F7[5]);
        case (opCode)
          OP_R: begin
            ALUASrc = ASRC_RS1;
            ALUBSrc = BSRC_RS2;
          end
          OP_I: begin
            ALUBSrc = BSRC_IMM;
            ImmSrc  = IMM_I;
          end
          OP_LUI: begin
            ALUBSrc = BSRC_IMM;
            ImmSrc  = IMM_U;
          end
          OP_AUIPC: begin
            ALUASrc = ASRC_OLDPC;
            ALUBSrc = BSRC_IMM;
            ImmSrc  = IMM_U;
          end
          default: begin
            ALUBSrc = BSRC_RS2;
          end
        endcase
        RUWr        = (state_q == S_ALUWB);
        InstRetired = (state_q == S_ALUWB);
        RUDataWrSrc = (state_q == S_ALUWB) ? WSRC_ALU : WSRC_PC;
      end
      // Address selects stay put through the whole access so the memory sees a stable address.
      S_MEMADDR, S_MEMRD, S_MEMWR: begin
        ALUASrc     = ASRC_RS1;
        ALUBSrc     = BSRC_IMM;
        ImmSrc      = (opCode == OP_STORE) ? IMM_S : IMM_I;
        DMRd        = (state_q == S_MEMRD);
        DMWr        = (state_q == S_MEMWR);
        DMCtrl      = (state_q == S_MEMADDR) ? 3'b000 : F3;
        InstRetired = (state_q == S_MEMWR) && MemReady;
      end
      S_MEMWB: begin
        RUWr        = 1'b1;
        RUDataWrSrc = WSRC_MEM;
        DMCtrl      = F3;
        InstRetired = 1'b1;
      end
      S_BRANCH: begin
        ALUASrc     = ASRC_OLDPC;
        ALUBSrc     = BSRC_IMM;
        ImmSrc      = IMM_B;
        PCWr        = BrTaken;
        InstRetired = 1'b1;
      end
      S_JUMP: begin
        RUWr        = 1'b1;
        RUDataWrSrc = WSRC_PC;
        PCWr        = 1'b1;
        InstRetired = 1'b1;
        ALUBSrc     = BSRC_IMM;
        ALUASrc     = (opCode == OP_JAL) ? ASRC_OLDPC : ASRC_RS1;
        ImmSrc      = (opCode == OP_JAL) ? IMM_J : IMM_I;
      end
      S_TRAP: begin
        IllegalInst = 1'b1;
      end
      default: begin
        IllegalInst = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench: stimulus pushes the hand-computed output vector for each cycle into a
// scoreboard queue; a negedge monitor pops and compares against the live DUT outputs.
module tb_multicycle_control_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] opCode;
  logic [2:0] F3;
  logic [6:0] F7;
  logic       BrTaken;
  logic       MemReady;
  logic       PCWr, IRWr, RUWr, DMRd, DMWr, InstRetired, IllegalInst;
  logic [1:0] ALUASrc, ALUBSrc, RUDataWrSrc;
  logic [3:0] ALUOp, State;
  logic [2:0] ImmSrc, DMCtrl;

  multicycle_control_fsm #(.RESET_STATE_HOLD(1)) dut (
    .CLK(CLK), .RST(RST), .opCode(opCode), .F3(F3), .F7(F7),
    .BrTaken(BrTaken), .MemReady(MemReady),
    .PCWr(PCWr), .IRWr(IRWr), .RUWr(RUWr), .DMRd(DMRd), .DMWr(DMWr),
    .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .DMCtrl(DMCtrl), .RUDataWrSrc(RUDataWrSrc), .State(State),
    .InstRetired(InstRetired), .IllegalInst(IllegalInst)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [26:0] v;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Order: State PCWr IRWr RUWr DMRd DMWr ASrc BSrc ALUOp ImmSrc DMCtrl WrSrc Ret Ill
  logic [26:0] act;
  assign act = {State, PCWr, IRWr, RUWr, DMRd, DMWr, ALUASrc, ALUBSrc, ALUOp,
                ImmSrc, DMCtrl, RUDataWrSrc, InstRetired, IllegalInst};

  function automatic logic [26:0] ev(input logic [3:0] st, input logic pcwr, input logic irwr,
                                     input logic ruwr, input logic dmrd, input logic dmwr,
                                     input logic [1:0] as, input logic [1:0] bs,
                                     input logic [3:0] op, input logic [2:0] imm,
                                     input logic [2:0] dmc, input logic [1:0] ws,
                                     input logic ret, input logic ill);
    return {st, pcwr, irwr, ruwr, dmrd, dmwr, as, bs, op, imm, dmc, ws, ret, ill};
  endfunction

  // Monitor: compare the queued expectation against the outputs mid-cycle
  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      mon_x = sb_q.pop_front();
      n_tests++;
      if (act !== mon_x.v) begin
        n_fail++;
        $display("FAIL %s: got %b want %b (state %0d)", mon_x.name, act, mon_x.v, State);
      end
    end
  end

  task automatic cyc(input string n, input logic [26:0] e);
    exp_t x;
    x.name = n;
    x.v    = e;
    sb_q.push_back(x);
    @(posedge CLK);
    #1;
  endtask

  logic [26:0] v_idle, v_fetch, v_dec;

  task automatic issue(input string n, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7);
    opCode = op;
    F3     = f3;
    F7     = f7;
    cyc({n, "_fetch"}, v_fetch);
    cyc({n, "_decode"}, v_dec);
  endtask

  initial begin
    RST = 1'b1; opCode = 7'd0; F3 = 3'd0; F7 = 7'd0; BrTaken = 1'b0; MemReady = 1'b0;
    v_idle  = ev(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0);
    v_fetch = ev(4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 4'b0000, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0);
    v_dec   = ev(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    cyc("reset", v_idle);
    RST = 1'b0;
    cyc("idle_hold", v_idle);

    // sub: R-type, F7[5]=1
    issue("sub", 7'b0110011, 3'b000, 7'b0100000);
    cyc("sub_exec",  ev(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1000, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0));
    cyc("sub_aluwb", ev(4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1000, 3'b000, 3'b000, 2'b10, 1'b1, 1'b0));
    // srai: I-type shift keeps F7[5]
    issue("srai", 7'b0010011, 3'b101, 7'b0100000);
    cyc("srai_exec",  ev(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 4'b1101, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0));
    cyc("srai_aluwb", ev(4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 4'b1101, 3'b000, 3'b000, 2'b10, 1'b1, 1'b0));
    // addi with immediate bit 30 set: must stay ADD
    issue("addi", 7'b0010011, 3'b000, 7'b0100000);
    cyc("addi_exec", ev(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0));
    cyc("addi_wb",   ev(4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 3'b000, 3'b000, 2'b10, 1'b1, 1'b0));
    // lui: pass B, U immediate
    issue("lui", 7'b0110111, 3'b000, 7'b0000000);
    cyc("lui_exec", ev(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 4'b1001, 3'b011, 3'b000, 2'b00, 1'b0, 1'b0));
    cyc("lui_wb",   ev(4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 4'b1001, 3'b011, 3'b000, 2'b10, 1'b1, 1'b0));

    // lw with three wait cycles: retire on cycle 8
    issue("lw", 7'b0000011, 3'b010, 7'b0000000);
    cyc("lw_addr", ev(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      cyc("lw_rd_wait", ev(4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 4'b0000, 3'b000, 3'b010, 2'b00, 1'b0, 1'b0));
    end
    MemReady = 1'b1;
    cyc("lw_rd_done", ev(4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 4'b0000, 3'b000, 3'b010, 2'b00, 1'b0, 1'b0));
    MemReady = 1'b0;
    cyc("lw_wb", ev(4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 3'b000, 3'b010, 2'b01, 1'b1, 1'b0));

    // sh with immediate MemReady: single-cycle MEMWR retires
    issue("sh", 7'b0100011, 3'b001, 7'b0000000);
    cyc("sh_addr", ev(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 3'b001, 3'b000, 2'b00, 1'b0, 1'b0));
    MemReady = 1'b1;
    cyc("sh_wr",   ev(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 4'b0000, 3'b001, 3'b001, 2'b00, 1'b1, 1'b0));
    MemReady = 1'b0;

    // beq taken / not taken
    BrTaken = 1'b1;
    issue("beq_t", 7'b1100011, 3'b000, 7'b0000000);
    cyc("beq_t_br", ev(4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 4'b0000, 3'b010, 3'b000, 2'b00, 1'b1, 1'b0));
    BrTaken = 1'b0;
    issue("beq_n", 7'b1100011, 3'b000, 7'b0000000);
    cyc("beq_n_br", ev(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 4'b0000, 3'b010, 3'b000, 2'b00, 1'b1, 1'b0));

    // jalr and jal
    issue("jalr", 7'b1100111, 3'b000, 7'b0000000);
    cyc("jalr_jump", ev(4'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 3'b000, 3'b000, 2'b00, 1'b1, 1'b0));
    issue("jal", 7'b1101111, 3'b000, 7'b0000000);
    cyc("jal_jump",  ev(4'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 4'b0000, 3'b100, 3'b000, 2'b00, 1'b1, 1'b0));

    // sw aborted by reset during the wait
    issue("sw", 7'b0100011, 3'b010, 7'b0000000);
    cyc("sw_addr", ev(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 3'b001, 3'b000, 2'b00, 1'b0, 1'b0));
    cyc("sw_wait", ev(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 4'b0000, 3'b001, 3'b010, 2'b00, 1'b0, 1'b0));
    RST = 1'b1;
    cyc("sw_wait_rst", ev(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 4'b0000, 3'b001, 3'b010, 2'b00, 1'b0, 1'b0));
    RST = 1'b0;
    cyc("sw_after_rst", v_idle);

    // illegal opcode traps until reset
    issue("ill", 7'b1111111, 3'b000, 7'b0000000);
    for (int i = 0; i < 3; i++) begin
      cyc("trap_hold", ev(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 3'b000, 3'b000, 2'b00, 1'b0, 1'b1));
    end
    RST = 1'b1;
    cyc("trap_rst", ev(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 3'b000, 3'b000, 2'b00, 1'b0, 1'b1));
    RST = 1'b0;
    cyc("trap_idle", v_idle);
    opCode = 7'b0110011;
    cyc("refetch", v_fetch);

    for (int i = 0; i < 4; i++) begin
      if (sb_q.size() > 0) @(negedge CLK);
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
